// File: rtl/debugger_frame_tx_pkg.sv
// Shared debugger definitions: transmit FSM states, dump header codes and
// byte-geometry helpers used by the frame serializer and its byte mux.
package debugger_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_CHECKSUM,
        ST_DONE
    } tx_state_e;

    localparam logic [7:0] REG_DUMP = 8'hA5;
    localparam logic [7:0] MEM_DUMP = 8'h5A;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 32 / BYTE_W;

    function automatic int bytes_per_word(input int word_size);
        return word_size / BYTE_W;
    endfunction

endpackage

// File: rtl/debugger_byte_mux.sv
// Selects byte n of a latched snapshot; words in ascending order, each word
// emitted most-significant byte first.
module debugger_byte_mux
    import debugger_frame_tx_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int N_WORDS   = 32,
    parameter int IDX_W     = 7
) (
    input  logic [N_WORDS*WORD_SIZE-1:0] snapshot,
    input  logic [IDX_W-1:0]             byte_idx,
    output logic [BYTE_W-1:0]            byte_sel
);

    localparam int BPW     = bytes_per_word(WORD_SIZE);
    localparam int N_BYTES = N_WORDS * BPW;

    logic [N_BYTES-1:0][BYTE_W-1:0] byte_arr;

    // Flatten to stream order so the index is simply the payload byte count.
    for (genvar w = 0; w < N_WORDS; w++) begin : g_word
        for (genvar b = 0; b < BPW; b++) begin : g_byte
            assign byte_arr[w*BPW + b] = snapshot[w*WORD_SIZE + (BPW-1-b)*BYTE_W +: BYTE_W];
        end
    end

    assign byte_sel = byte_arr[byte_idx];

endmodule

// File: rtl/debugger_frame_tx.sv
// Frames a latched debug snapshot as header, big-endian payload bytes and an
// XOR checksum, written to the UART tx FIFO with full-flag back-pressure.
module debugger_frame_tx
    import debugger_frame_tx_pkg::*;
#(
    parameter int UART_BUS_SIZE = 8,
    parameter int WORD_SIZE     = 32,
    parameter int N_WORDS       = 32,
    parameter int DATA_BUS_SIZE = N_WORDS * WORD_SIZE
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [UART_BUS_SIZE-1:0] i_header,
    input  logic [DATA_BUS_SIZE-1:0] i_data_bus,
    input  logic                     i_uart_full,
    output logic                     o_uart_wr,
    output logic [UART_BUS_SIZE-1:0] o_uart_data_wr,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int N_BYTES = N_WORDS * bytes_per_word(WORD_SIZE);
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    tx_state_e                state, state_nxt;
    logic [DATA_BUS_SIZE-1:0] snap;
    logic [UART_BUS_SIZE-1:0] header_q;
    logic [UART_BUS_SIZE-1:0] csum;
    logic [IDX_W-1:0]         idx;
    logic [BYTE_W-1:0]        payload_byte;

    debugger_byte_mux #(
        .WORD_SIZE(WORD_SIZE),
        .N_WORDS  (N_WORDS),
        .IDX_W    (IDX_W)
    ) u_byte_mux (
        .snapshot(snap),
        .byte_idx(idx),
        .byte_sel(payload_byte)
    );

    // The presented byte depends only on state, so it holds steady across stalls.
    always_comb begin
        state_nxt      = state;
        o_uart_wr      = 1'b0;
        o_uart_data_wr = '0;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                o_busy         = 1'b1;
                o_uart_data_wr = header_q;
                o_uart_wr      = !i_uart_full;
                if (!i_uart_full) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                o_busy         = 1'b1;
                o_uart_data_wr = payload_byte;
                o_uart_wr      = !i_uart_full;
                if (!i_uart_full && idx == LAST_IDX) state_nxt = ST_CHECKSUM;
            end
            ST_CHECKSUM: begin
                o_busy         = 1'b1;
                o_uart_data_wr = csum;
                o_uart_wr      = !i_uart_full;
                if (!i_uart_full) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            snap     <= '0;
            header_q <= '0;
            csum     <= '0;
            idx      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && i_start) begin
                snap     <= i_data_bus;
                header_q <= i_header;
                csum     <= '0;
                idx      <= '0;
            end
            if (o_uart_wr) csum <= csum ^ o_uart_data_wr;
            // Terminal index is left in place; the next start reloads it.
            if (o_uart_wr && state == ST_DATA && idx != LAST_IDX) idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_debugger_frame_tx.sv
// Bench for debugger_frame_tx: cycle tables on a 2-word instance, plus model-checked
// default-size frames with random data and random FIFO back-pressure.
module tb_debugger_frame_tx;

    localparam logic [63:0] NOM_BUS = {32'hAABBCCDD, 32'h11223344};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_start, s_full, s_wr, s_busy, s_done;
    logic [7:0]  s_header, s_data;
    logic [63:0] s_bus;

    logic          l_start, l_full, l_wr, l_busy, l_done;
    logic [7:0]    l_header, l_data;
    logic [1023:0] l_bus;

    debugger_frame_tx #(.N_WORDS(2)) dut_s (
        .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_header(s_header),
        .i_data_bus(s_bus), .i_uart_full(s_full), .o_uart_wr(s_wr),
        .o_uart_data_wr(s_data), .o_busy(s_busy), .o_done(s_done)
    );

    debugger_frame_tx dut_l (
        .i_clk(clk), .i_reset(rst), .i_start(l_start), .i_header(l_header),
        .i_data_bus(l_bus), .i_uart_full(l_full), .o_uart_wr(l_wr),
        .o_uart_data_wr(l_data), .o_busy(l_busy), .o_done(l_done)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_l[$];
    int         wcyc_l[$];
    always @(negedge clk) begin
        if (l_wr) begin
            got_l.push_back(l_data);
            wcyc_l.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         start;
        bit         full;
        bit         zero;
        bit         wr;
        logic [7:0] data;
        bit         busy;
        bit         done;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] frame_a [10] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44,
                                 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hE1};

    task automatic add_vec(input bit st, input bit fu, input bit ze, input bit wr,
                           input logic [7:0] d, input bit bu, input bit dn);
        vec_t v;
        v.start = st; v.full = fu; v.zero = ze; v.wr = wr;
        v.data = d; v.busy = bu; v.done = dn;
        vecs.push_back(v);
    endtask

    // One cycle per entry: start pulse, 10 byte writes (with optional stall), done.
    task automatic add_frame(input int stall_idx, input int stall_n, input bit zero,
                             input int restart_idx);
        add_vec(1, 0, 0, 0, 8'h00, 0, 0);
        for (int j = 0; j < 10; j++) begin
            if (j == stall_idx)
                for (int s = 0; s < stall_n; s++) add_vec(0, 1, zero, 0, frame_a[j], 1, 0);
            add_vec(j == restart_idx, 0, zero, 1, frame_a[j], 1, 0);
        end
        add_vec(0, 0, zero, 0, 8'h00, 0, 1);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            s_start = vecs[i].start;
            s_full  = vecs[i].full;
            s_bus   = vecs[i].zero ? 64'h0 : NOM_BUS;
            @(negedge clk);
            chk($sformatf("%s_v%0d_wr", tag, i), s_wr, vecs[i].wr);
            chk($sformatf("%s_v%0d_busy", tag, i), s_busy, vecs[i].busy);
            chk($sformatf("%s_v%0d_done", tag, i), s_done, vecs[i].done);
            if (vecs[i].busy) chk($sformatf("%s_v%0d_data", tag, i), s_data, vecs[i].data);
        end
        vecs.delete();
    endtask

    // Reference: header, words 0..31 each MSB first, then XOR of everything sent.
    task automatic run_big(input logic [7:0] hdr, input logic [1023:0] bus,
                           input bit stress, input string tag);
        logic [7:0] exp[$];
        logic [7:0] cs;
        logic [7:0] x;
        int c0, dc, n;
        bit seen;
        exp.push_back(hdr);
        cs = hdr;
        for (int k = 0; k < 32; k++) begin
            for (int b = 3; b >= 0; b--) begin
                x = bus[k*32 + b*8 +: 8];
                exp.push_back(x);
                cs ^= x;
            end
        end
        exp.push_back(cs);
        got_l.delete();
        wcyc_l.delete();
        @(posedge clk); #1;
        l_header = hdr; l_bus = bus; l_start = 1'b1;
        l_full = stress && ($urandom_range(0, 99) < 30);
        @(negedge clk);
        c0 = cyc;
        dc = 0;
        seen = 1'b0;
        for (int budget = 0; budget < 2000 && !seen; budget++) begin
            @(posedge clk); #1;
            l_start = stress && ($urandom_range(0, 19) == 0);
            l_full  = stress && ($urandom_range(0, 99) < 30);
            if (stress) for (int k = 0; k < 32; k++) l_bus[k*32 +: 32] = $urandom;
            @(negedge clk);
            if (l_done) begin
                seen = 1'b1;
                dc = cyc;
            end
        end
        @(posedge clk); #1;
        l_start = 1'b0;
        l_full  = 1'b0;
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_nbytes"}, got_l.size(), exp.size());
        n = (got_l.size() < exp.size()) ? got_l.size() : exp.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got_l[i], exp[i]);
        if (!stress && wcyc_l.size() == 130) begin
            chk({tag, "_first_wr_cyc"}, wcyc_l[0] - c0, 1);
            chk({tag, "_last_wr_cyc"}, wcyc_l[129] - c0, 130);
            chk({tag, "_done_cyc"}, dc - c0, 131);
            chk({tag, "_csum_const"}, got_l[129], 8'h5A);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1023:0] bus;
        int wr_cnt, done_cnt;
        rst = 1'b1;
        s_start = 0; s_full = 0; s_header = 8'hA5; s_bus = NOM_BUS;
        l_start = 0; l_full = 0; l_header = 8'h00; l_bus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_wr", s_wr, 0);
        chk("rst_s_data", s_data, 0);
        chk("rst_s_busy", s_busy, 0);
        chk("rst_s_done", s_done, 0);
        chk("rst_l_wr", l_wr, 0);
        chk("rst_l_data", l_data, 0);
        chk("rst_l_busy", l_busy, 0);
        chk("rst_l_done", l_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // nominal, stall on 0x33, bus cleared after start, restart ignored, back-to-back
        add_frame(-1, 0, 0, -1);
        add_frame(3, 3, 0, -1);
        add_frame(-1, 0, 1, -1);
        add_frame(-1, 0, 0, 5);
        add_frame(-1, 0, 0, -1);
        add_vec(0, 0, 0, 0, 8'h00, 0, 0);
        run_vecs("tbl");

        // reset after the fourth byte aborts the frame
        @(posedge clk); #1;
        s_start = 1'b1; s_bus = NOM_BUS;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            s_start = 1'b0;
            if (j == 4) rst = 1'b1;
            @(negedge clk);
            chk($sformatf("rst_mid_wr%0d", j), s_wr, 1);
            chk($sformatf("rst_mid_data%0d", j), s_data, frame_a[j-1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr_after", s_wr, 0);
        chk("rst_mid_busy_after", s_busy, 0);
        wr_cnt = 0; done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (s_wr) wr_cnt++;
            if (s_done) done_cnt++;
        end
        chk("rst_mid_no_wr", wr_cnt, 0);
        chk("rst_mid_no_done", done_cnt, 0);
        add_frame(-1, 0, 0, -1);
        add_vec(0, 0, 0, 0, 8'h00, 0, 0);
        run_vecs("post_rst");

        // default size, word k = k, header 0x5A
        for (int k = 0; k < 32; k++) bus[k*32 +: 32] = 32'(k);
        run_big(8'h5A, bus, 1'b0, "t6");

        // random content with random back-pressure and stray starts
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 32; k++) bus[k*32 +: 32] = $urandom;
            run_big(8'($urandom_range(0, 255)), bus, 1'b1, $sformatf("rnd%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debugger_frame_tx.md
Name: debugger_frame_tx

Overview:
Serializes a wide debug snapshot (register bank or data memory contents) into a framed byte stream for the UART transmit FIFO. The frame is header byte, payload bytes, XOR checksum. It sits inside the debugger path, between the MIPS content buses and the UART write port. It is the transmit/dump counterpart to the debugger's receive and instruction-load path.

Parameters:
- UART_BUS_SIZE, 8, byte width on the UART side; must be 8.
- WORD_SIZE, 32, bits per content word; must be a multiple of 8.
- N_WORDS, 32, words per snapshot; must be at least 1.
- DATA_BUS_SIZE, N_WORDS*WORD_SIZE, width of the snapshot bus. Derived; do not override independently.

Ports:
- i_clk  in  1  single clock, shared with the UART and MIPS.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to send a frame; honoured only in IDLE.
- i_header  in  UART_BUS_SIZE  frame header byte; latched with i_start.
- i_data_bus  in  DATA_BUS_SIZE  snapshot; word k occupies bits [k*WORD_SIZE +: WORD_SIZE].
- i_uart_full  in  1  UART tx FIFO full.
- o_uart_wr  out  1  write strobe to the UART tx FIFO.
- o_uart_data_wr  out  UART_BUS_SIZE  byte presented with o_uart_wr.
- o_busy  out  1  high from the cycle after an accepted start through the last byte write.
- o_done  out  1  one-cycle pulse after the checksum byte is written.

Behaviour:
- Reset is synchronous and active-high. It drives state to IDLE and clears the counters, latches and checksum. o_uart_wr=0, o_uart_data_wr=0, o_busy=0, o_done=0.
- Reset mid-frame aborts the frame at once: no further writes and no o_done. The next frame starts clean.
- FSM states: IDLE, HEADER, DATA, CHECKSUM, DONE.
- IDLE: on i_start=1, latch i_data_bus and i_header into internal registers, clear checksum to 0, go to HEADER. Later changes on i_data_bus do not affect the frame.
- i_start is ignored in every state other than IDLE; no queuing.
- Write rule: o_uart_wr = (state is HEADER, DATA or CHECKSUM) and !i_uart_full.
  - This path is combinational from registered state and i_uart_full.
  - o_uart_data_wr is a registered or state-selected byte, stable while a byte is stalled.
  - A byte advances only on a cycle where o_uart_wr=1. While i_uart_full=1 the FSM holds and no byte is lost or duplicated.
- HEADER: send the latched header, then go to DATA.
- DATA: byte index runs 0 .. N_WORDS*(WORD_SIZE/8)-1.
  - Words go out in order 0..N_WORDS-1.
  - Within each word, bytes go out MSB first (big-endian).
  - After the last payload byte is written, go to CHECKSUM.
- Checksum: XOR of the header and all payload bytes. It is updated on each accepted write; CHECKSUM sends the accumulated value, then goes to DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=0, then return to IDLE. A new i_start is accepted in the cycle after DONE.
- Latency with i_uart_full held low:
  - i_start at cycle 0 gives the header write at cycle 1.
  - Writes are back-to-back, one byte per cycle: N_WORDS*WORD_SIZE/8 + 2 writes in total.
  - o_done comes the cycle after the checksum write.
- o_busy=1 in HEADER, DATA and CHECKSUM; 0 in IDLE and DONE.
- i_uart_full asserted at the same cycle as a pending byte: no write that cycle, and the byte is retried the next non-full cycle.
- Index counter width: $clog2(N_WORDS*WORD_SIZE/8) bits, minimum 1. It never wraps inside a frame; the terminal count is compared explicitly.

Decomposition:
- Shared debugger package holds:
  - state encoding localparams (IDLE/HEADER/DATA/CHECKSUM/DONE);
  - header codes, e.g. REG_DUMP=8'hA5, MEM_DUMP=8'h5A;
  - the bytes-per-word constant.
- One natural sub-module: debugger_byte_mux. It is combinational and selects byte n of the latched snapshot, big-endian within the word. The FSM, counter and checksum stay in the top of this block.

Test Plan:
1. N_WORDS=2, header 8'hA5, data {word1=32'hAABBCCDD, word0=32'h11223344}, i_start pulse, full=0 -> writes A5 11 22 33 44 AA BB CC DD E1 on cycles 1..10, o_done at cycle 11, o_busy high on cycles 1..10.
2. Same frame, i_uart_full=1 for 3 cycles while the byte 33 is pending -> no write during the stall, 33 written once when full drops, byte sequence identical to test 1.
3. i_data_bus changed to all-zero one cycle after start -> output identical to test 1 (snapshot latched).
4. i_start re-pulsed during DATA -> ignored, exactly one frame of 10 bytes. A pulse in the cycle after DONE starts a second frame.
5. i_reset asserted after 4 bytes are written -> o_uart_wr=0 the next cycle, no o_done. A new start then produces a full correct frame beginning with A5.
6. Default params (N_WORDS=32), data word k = k, header 8'h5A -> 130 writes: 5A, then 00 00 00 k for each k, then checksum 8'h5A^(XOR of 0..31)=8'h5A.
